// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Key codes are row*4+col, so bit positions in the pressed map equal key codes.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_e;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;

  localparam logic [7:0] KEY_NONE = 8'h00;

  // Priority pick: the lowest-numbered pressed key wins.
  function automatic logic [3:0] lowest_index(input logic [15:0] map);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (map[4'(i)]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines.
// Resets to all-ones, which reads as "no key pressed".
module row_sync (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [3:0] row_in,
  output logic [3:0] row_out
);

  logic [3:0] meta_q, meta_d;
  logic [3:0] sync_q, sync_d;

  always_comb begin
    meta_d = row_in;
    sync_d = meta_q;
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign row_out = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column walk, pressed-map assembly and
// press/release debounce producing a one-cycle KEY_EVENT per accepted press.
//
//   state      | meaning
//   -----------+-------------------------------------------------------
//   IDLE       | no key accepted, waiting for a non-empty frame
//   PRESS_DB   | candidate key seen, counting consecutive frames with it
//   HELD       | key accepted and still held, KEY_VALID high
//   RELEASE_DB | empty frames seen, counting toward a confirmed release
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       CK,
  input  logic       RST_N,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [7:0] KEY,
  output logic       KEY_EVENT,
  output logic       KEY_VALID
);

  localparam int              DIV_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 2;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]      DB_N     = 4'(DEBOUNCE_FRAMES);

  logic [3:0]       row_s;

  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [15:0]      map_q, map_d;
  logic [15:0]      map_full;

  state_e           state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [7:0]       key_q, key_d;
  logic             event_q, event_d;
  logic             valid_q, valid_d;

  logic             col_last;
  logic             frame_end;
  logic             map_empty;
  logic [3:0]       cnt_inc;
  logic [3:0]       first_idx;

  row_sync u_row_sync (
    .CK      (CK),
    .RST_N   (RST_N),
    .row_in  (ROW),
    .row_out (row_s)
  );

  assign col_last  = (div_q == DIV_LAST);
  assign frame_end = col_last && (col_q == 2'd3);

  always_comb begin
    div_d = div_q;
    col_d = col_q;
    if (col_last) begin
      div_d = '0;
      col_d = col_q + 2'd1;
    end else begin
      div_d = div_q + 1'b1;
    end
  end

  // map_full is map_q with the current column's bits overlaid, so the
  // frame-end decision already sees column 3 without waiting a cycle.
  always_comb begin
    map_full = map_q;
    for (int r = 0; r < NUM_ROWS; r++) begin
      map_full[{2'(r), col_q}] = ~row_s[2'(r)];
    end
    map_d = map_q;
    if (col_last) begin
      map_d = frame_end ? 16'h0000 : map_full;
    end
  end

  assign map_empty = (map_full == 16'h0000);
  assign cnt_inc   = cnt_q + 4'd1;
  assign first_idx = lowest_index(map_full);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    event_d = 1'b0;
    valid_d = valid_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (!map_empty) begin
            cand_d = first_idx;
            cnt_d  = 4'd1;
            if (DB_N == 4'd1) begin
              key_d   = {4'b0000, first_idx};
              event_d = 1'b1;
              valid_d = 1'b1;
              state_d = HELD;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          // Other keys appearing alongside the candidate do not disturb the count.
          if (map_full[cand_q]) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_N) begin
              key_d   = {4'b0000, cand_q};
              event_d = 1'b1;
              valid_d = 1'b1;
              state_d = HELD;
            end
          end else begin
            cnt_d   = 4'd0;
            state_d = IDLE;
          end
        end
        HELD: begin
          if (map_empty) begin
            cnt_d = 4'd1;
            if (DB_N == 4'd1) begin
              valid_d = 1'b0;
              state_d = IDLE;
            end else begin
              state_d = RELEASE_DB;
            end
          end
        end
        RELEASE_DB: begin
          if (map_empty) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_N) begin
              valid_d = 1'b0;
              state_d = IDLE;
            end
          end else begin
            state_d = HELD;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CK or negedge RST_N) begin
    if (!RST_N) begin
      div_q   <= '0;
      col_q   <= 2'd0;
      map_q   <= 16'h0000;
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= 4'd0;
      key_q   <= KEY_NONE;
      event_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      col_q   <= col_d;
      map_q   <= map_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      event_q <= event_d;
      valid_q <= valid_d;
    end
  end

  assign COL       = ~(4'b0001 << col_q);
  assign KEY       = key_q;
  assign KEY_EVENT = event_q;
  assign KEY_VALID = valid_q;

endmodule
